// File: rtl/window_tap_buffer_if.sv
// Sample-in / tap-set-out handshake bundle for window_tap_buffer.
// Slave modport is the buffer side; master is the producer/consumer side.
interface window_tap_buffer_if #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned SHORT_LEN = 16,
    parameter int unsigned LONG_LEN  = 32
);
    localparam int unsigned SSW = DATA_W + $clog2(SHORT_LEN);
    localparam int unsigned LSW = DATA_W + $clog2(LONG_LEN);
    localparam int unsigned FW  = $clog2(SHORT_LEN + LONG_LEN + 2);

    logic signed [DATA_W-1:0] in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] first_short;
    logic signed [DATA_W-1:0] last_short;
    logic signed [DATA_W-1:0] first_long;
    logic signed [DATA_W-1:0] last_long;
    logic signed [SSW-1:0]    short_sum;
    logic signed [LSW-1:0]    long_sum;
    logic [FW-1:0]            fill_count;
    logic                     init_done;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_valid, first_short, last_short, first_long, last_long,
               short_sum, long_sum, fill_count, init_done
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_valid, first_short, last_short, first_long, last_long,
               short_sum, long_sum, fill_count, init_done
    );
endinterface

// File: rtl/window_tap_buffer.sv
// Circular sliding-window sample store with short/long window edge taps.
// Running sums are built only when WTB_RUNNING_SUM_EN is defined; otherwise tied to 0.
module window_tap_buffer #(
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned SHORT_LEN = 16,
    parameter int unsigned LONG_LEN  = 32
) (
    input logic                clock,
    input logic                reset,
    window_tap_buffer_if.slave bus
);
    localparam int unsigned D     = SHORT_LEN + LONG_LEN;
    localparam int unsigned DEPTH = D + 1;
    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned FW    = $clog2(D + 2);
    localparam logic [PW-1:0] WPTR_LAST = PW'(D);
    localparam logic [FW-1:0] FILL_MAX  = FW'(D + 1);

    logic signed [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]            wptr;
    logic                     accept;
    logic signed [DATA_W-1:0] tap_last_short;
    logic signed [DATA_W-1:0] tap_first_long;
    logic signed [DATA_W-1:0] tap_last_long;

    // Index of the sample k places older than the slot about to be written.
    function automatic logic [PW-1:0] back(input logic [PW-1:0] p, input int unsigned k);
        int unsigned t;
        t = 32'(p) + DEPTH - k;
        if (t >= DEPTH) t = t - DEPTH;
        return PW'(t);
    endfunction

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // All tap offsets are >= 1, so these read pre-write contents of the array.
    assign tap_last_short = mem[back(wptr, SHORT_LEN - 1)];
    assign tap_first_long = mem[back(wptr, SHORT_LEN)];
    assign tap_last_long  = mem[back(wptr, D - 1)];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            wptr            <= '0;
            bus.out_valid   <= 1'b0;
            bus.first_short <= '0;
            bus.last_short  <= '0;
            bus.first_long  <= '0;
            bus.last_long   <= '0;
            bus.fill_count  <= '0;
            bus.init_done   <= 1'b0;
        end else if (accept) begin
            mem[wptr]       <= bus.in_data;
            wptr            <= (wptr == WPTR_LAST) ? '0 : wptr + 1'b1;
            bus.out_valid   <= 1'b1;
            bus.first_short <= bus.in_data;
            bus.last_short  <= tap_last_short;
            bus.first_long  <= tap_first_long;
            bus.last_long   <= tap_last_long;
            if (bus.fill_count != FILL_MAX) bus.fill_count <= bus.fill_count + 1'b1;
            if (bus.fill_count == FILL_MAX - 1'b1) bus.init_done <= 1'b1;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

`ifdef WTB_RUNNING_SUM_EN
    localparam int unsigned SSW = DATA_W + $clog2(SHORT_LEN);
    localparam int unsigned LSW = DATA_W + $clog2(LONG_LEN);

    logic signed [SSW-1:0]    short_acc;
    logic signed [LSW-1:0]    long_acc;
    logic signed [DATA_W-1:0] tap_oldest;

    // Sample leaving the long window; it sits in the slot just after wptr.
    assign tap_oldest = mem[back(wptr, D)];

    always_ff @(posedge clock) begin
        if (reset) begin
            short_acc <= '0;
            long_acc  <= '0;
        end else if (accept) begin
            short_acc <= short_acc + SSW'(bus.in_data) - SSW'(tap_first_long);
            long_acc  <= long_acc + LSW'(tap_first_long) - LSW'(tap_oldest);
        end
    end

    assign bus.short_sum = short_acc;
    assign bus.long_sum  = long_acc;
`else
    assign bus.short_sum = '0;
    assign bus.long_sum  = '0;
`endif
endmodule
